ifexe_skid_reg: RTL and testbench
=================================

# ifexe_skid_reg

Parametrised IF→EXE pipeline register for the three-stage RISC-V core. It carries instruction, PC and a packed control word with a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, a synchronous flush for branch/jump redirects, and a saturating stall counter. When nothing valid is held, it presents a NOP bubble with all control bits cleared, so the EXE stage never writes architectural state.

## Interface
- `DATA_W`, 32: instruction and PC width.
- `CTRL_W`, 16: packed control width (A_sel, B_sel, CSR_sel, CSR_WE, ALU_sel, Reg_WE, DMEM_sel, LOAD_sel, WB_sel, plus spare bits).
- `NOP_INSTR`, 32'h0000_0013: instruction presented during bubbles (`addi x0,x0,0`).
- `CNT_W`, 16: stall counter width.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low. Asserting it clears all state immediately. Release is sampled on `clk`.
- `in_valid` in 1: IF presents a valid instruction.
- `in_ready` out 1: stage can accept. Registered, equal to !skid_valid.
- `in_instr` in DATA_W: fetched instruction.
- `in_pc` in DATA_W: its PC.
- `in_ctrl` in CTRL_W: decoded control.
- `flush` in 1: discard all held and incoming entries this cycle.
- `out_valid` out 1: main entry valid.
- `out_ready` in 1: EXE consumes the main entry.
- `out_instr` out DATA_W: main instruction; NOP_INSTR when !out_valid.
- `out_pc` out DATA_W: main PC; holds its last value when !out_valid.
- `out_ctrl` out CTRL_W: main control; all zeros when !out_valid.
- `stall_cnt` out CNT_W: saturating count of cycles with out_valid && !out_ready.

## Operation
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept → FULL.
  - FULL (01):
    - accept && consume → FULL, main loads the new entry.
    - accept && !consume → SKID, skid loads the new entry.
    - !accept && consume → EMPTY.
    - otherwise hold.
  - SKID (11): in_ready = 0, so no accept is possible. Consume → FULL, main ← skid, skid cleared. Otherwise hold.
- Ordering is strict FIFO: the skid entry always leaves after the main entry.
- Flush has priority over everything:
  - next state is EMPTY, and any same-cycle accept is dropped.
  - A same-cycle consume still completes, because EXE sampled it.
  - Data registers are not cleared; output masking produces the NOP.
- Bubble masking is combinational from main_valid: out_instr = NOP_INSTR and out_ctrl = 0 when !main_valid.
- stall_cnt:
  - Increments by 1 each cycle out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by reset.
- Payload registers load only on accept or skid→main transfer. There is no enable toggling otherwise, so data stays stable under stall.

## Timing
- Reset values:
  - main_valid = skid_valid = 0, so out_valid = 0 and in_ready = 1.
  - out_instr = NOP_INSTR, out_pc = 0, out_ctrl = 0.
  - Skid payload = 0 and stall_cnt = 0.
- Latency is 1 cycle: accept at edge N gives out_valid = 1 with that payload after edge N.
- Throughput is 1 per cycle with out_ready held high; in_ready stays 1 throughout.
- in_ready falls one cycle after the skid fills and rises one cycle after it drains. It has no combinational path from out_ready.
- A reset asserted mid-operation clears the held entries immediately, with no clock edge needed. The first accept is possible on the first edge after release.
- Flush and back-pressure in the same cycle give EMPTY next cycle; stall_cnt does not increment that cycle.

## Test plan
- **Reset:** drive rst=0 mid-stream with both entries held → out_valid=0, in_ready=1, out_instr=32'h13, out_ctrl=0 before the next edge.
- **Streaming:** out_ready=1, feed PCs 0x0,0x4,0x8 back-to-back → out_pc 0x0,0x4,0x8 on consecutive cycles, one cycle after each accept; in_ready never drops.
- **Back-pressure:** out_ready=0 from cycle 2, feeding 0x0,0x4,0x8 →
  - FULL then SKID; in_ready=0 from cycle 3, and 0x8 is held off.
  - Release out_ready → order 0x0,0x4,0x8 with no loss or duplication.
  - stall_cnt equals the number of stalled cycles.
- **Flush in SKID:** flush in SKID state with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; the incoming entry never appears.
- **Flush with consume:** flush with out_ready=1 in FULL → the held entry counts as consumed once; EMPTY next cycle.
- **Saturation:** CNT_W=4, stall 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/ifexe_skid_reg.sv
// IF->EXE pipeline register with a two-entry skid buffer.
// Carries instruction, PC and packed control with a valid/ready handshake.
// A synchronous flush discards held entries for branch/jump redirects.
// A saturating counter tracks back-pressure cycles.
// Whenever no valid entry is held, the EXE stage sees a NOP bubble with all
// control bits cleared, so it cannot write architectural state.
module ifexe_skid_reg #(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy encoded as {skid_valid, main_valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    logic              main_valid_reg, main_valid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] main_instr_reg, main_pc_reg;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [DATA_W-1:0] skid_instr_reg, skid_pc_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic accept;
    logic consume;
    logic main_load_in;
    logic main_load_skid;
    logic skid_load;
    logic stall_inc;

    // in_ready comes straight from the skid flag, so there is no
    // combinational path from out_ready back to IF.
    assign in_ready  = ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign accept    = in_valid & in_ready;
    assign consume   = main_valid_reg & out_ready;
    assign stall_inc = main_valid_reg & ~out_ready & ~flush;

    // Occupancy next-state and payload load selects; flush overrides everything.
    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_load_in    = 1'b0;
        main_load_skid  = 1'b0;
        skid_load       = 1'b0;
        if (flush) begin
            // A same-cycle consume still completes on the EXE side; the
            // register simply ends up empty and drops any incoming entry.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            case ({skid_valid_reg, main_valid_reg})
                ST_EMPTY: begin
                    if (accept) begin
                        main_valid_next = 1'b1;
                        main_load_in    = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_load_in = 1'b1;
                    end else if (accept) begin
                        skid_valid_next = 1'b1;
                        skid_load       = 1'b1;
                    end else if (consume) begin
                        main_valid_next = 1'b0;
                    end
                end
                ST_SKID: begin
                    // No accept possible here; drain skid into main in order.
                    if (consume) begin
                        main_load_skid  = 1'b1;
                        skid_valid_next = 1'b0;
                    end
                end
                default: begin
                    // Skid-without-main is unreachable; recover to empty.
                    main_valid_next = 1'b0;
                    skid_valid_next = 1'b0;
                end
            endcase
        end
    end

    // Occupancy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    // Main payload: loads only from IF on accept or from skid on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_instr_reg <= '0;
            main_pc_reg    <= '0;
            main_ctrl_reg  <= '0;
        end else if (main_load_in) begin
            main_instr_reg <= in_instr;
            main_pc_reg    <= in_pc;
            main_ctrl_reg  <= in_ctrl;
        end else if (main_load_skid) begin
            main_instr_reg <= skid_instr_reg;
            main_pc_reg    <= skid_pc_reg;
            main_ctrl_reg  <= skid_ctrl_reg;
        end
    end

    // Skid payload: captures the entry that arrives while main is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            skid_ctrl_reg  <= '0;
        end else if (skid_load) begin
            skid_instr_reg <= in_instr;
            skid_pc_reg    <= in_pc;
            skid_ctrl_reg  <= in_ctrl;
        end
    end

    // Saturating count of stalled cycles; a flush cycle is not a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign out_pc    = main_pc_reg;
    assign out_instr = main_valid_reg ? main_instr_reg : NOP_INSTR;

    // Bubble masking: every control bit is gated by main_valid.
    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = main_ctrl_reg[gi] & main_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ifexe_skid_reg.sv
// Scoreboard bench for ifexe_skid_reg: the driver pushes each accepted
// entry, the monitor pops and compares on every consume.
module tb_ifexe_skid_reg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_instr = '0;
    logic [DW-1:0] in_pc = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [DW-1:0] out_pc;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int n_consumed = 0;
    logic [2*DW+CW-1:0] exp_q[$];

    ifexe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_INSTR(NOP), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] pc);
        return 16'h8000 | pc[CW-1:0];
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive one cycle of inputs starting at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        in_ctrl   = ctrl_of(pc);
        out_ready = rdy;
        flush     = fl;
        if (v && in_ready && !fl)
            exp_q.push_back({pc, instr_of(pc), ctrl_of(pc)});
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ov, input logic ir,
                               input logic [NW-1:0] sc);
        check({tag, "_out_valid"}, 80'(out_valid), 80'(ov));
        check({tag, "_in_ready"}, 80'(in_ready), 80'(ir));
        check({tag, "_stall_cnt"}, 80'(stall_cnt), 80'(sc));
    endtask

    // Monitor: mid-cycle, compare every consumed entry and every bubble.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_consume", 80'(out_pc), 80'hFFFF_FFFF);
                end else begin
                    logic [2*DW+CW-1:0] e;
                    e = exp_q.pop_front();
                    check("mon_consume", 80'({out_pc, out_instr, out_ctrl}), 80'(e));
                end
            end
            if (!out_valid) begin
                check("mon_bubble", 80'({out_instr, out_ctrl}), 80'({NOP, 16'h0}));
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and release.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_state("reset", 1'b0, 1'b1, 4'd0);
        check("reset_out_instr", 80'(out_instr), 80'(NOP));
        check("reset_out_pc", 80'(out_pc), 80'h0);
        check("reset_out_ctrl", 80'(out_ctrl), 80'h0);

        // Streaming at full rate.
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        check("stream_pc0", 80'(out_pc), 80'h0);
        check_state("stream0", 1'b1, 1'b1, 4'd0);
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        check("stream_pc4", 80'(out_pc), 80'h4);
        check_state("stream1", 1'b1, 1'b1, 4'd0);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        check("stream_pc8", 80'(out_pc), 80'h8);
        check_state("stream2", 1'b1, 1'b1, 4'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("stream_drain", 1'b0, 1'b1, 4'd0);

        // Back-pressure into the skid entry.
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        check_state("bp_full", 1'b1, 1'b1, 4'd0);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        check_state("bp_skid", 1'b1, 1'b0, 4'd1);
        check("bp_skid_pc", 80'(out_pc), 80'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        check_state("bp_hold1", 1'b1, 1'b0, 4'd2);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        check_state("bp_hold2", 1'b1, 1'b0, 4'd3);
        check("bp_hold_pc", 80'(out_pc), 80'h0);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        check_state("bp_release", 1'b1, 1'b1, 4'd3);
        check("bp_release_pc", 80'(out_pc), 80'h4);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        check("bp_last_pc", 80'(out_pc), 80'h8);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("bp_drain", 1'b0, 1'b1, 4'd3);

        // Flush while in SKID with an incoming entry.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        check_state("fs_full", 1'b1, 1'b1, 4'd3);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        check_state("fs_skid", 1'b1, 1'b0, 4'd4);
        drive(1'b1, 32'h18, 1'b0, 1'b1);
        check_state("fs_flushed", 1'b0, 1'b1, 4'd4);
        check("fs_out_ctrl", 80'(out_ctrl), 80'h0);
        check("fs_out_instr", 80'(out_instr), 80'(NOP));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("fs_after", 1'b0, 1'b1, 4'd4);
        check("fs_pc_hold", 80'(out_pc), 80'h10);

        // Flush together with a consume.
        drive(1'b1, 32'h20, 1'b1, 1'b0);
        check("fc_pc", 80'(out_pc), 80'h20);
        drive(1'b1, 32'h24, 1'b1, 1'b1);
        check_state("fc_flushed", 1'b0, 1'b1, 4'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("fc_after", 1'b0, 1'b1, 4'd4);

        // Stall counter saturation.
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        check_state("sat_full", 1'b1, 1'b1, 4'd4);
        for (int i = 0; i < 20; i++) begin
            int e;
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            e = (5 + i > 15) ? 15 : 5 + i;
            check("sat_cnt", 80'(stall_cnt), 80'(e));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("sat_drain", 1'b0, 1'b1, 4'd15);

        // Asynchronous reset with both entries held.
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        check_state("rst_skid", 1'b1, 1'b0, 4'd15);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        #2;
        check_state("rst_async", 1'b0, 1'b1, 4'd0);
        check("rst_async_instr", 80'(out_instr), 80'(NOP));
        check("rst_async_ctrl", 80'(out_ctrl), 80'h0);
        check("rst_async_pc", 80'(out_pc), 80'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        check("post_rst_pc", 80'(out_pc), 80'h50);
        check_state("post_rst", 1'b1, 1'b1, 4'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("post_rst_drain", 1'b0, 1'b1, 4'd0);

        @(negedge clk);
        check("final_consumed", 80'(n_consumed), 80'd9);
        check("final_queue_empty", 80'(exp_q.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
